if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_stage_if.sv | 19 +
 rtl/if_inst_buf.sv | 35 +++
 rtl/if_stage.sv | 52 +++++
 tb/tb_if_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: bus widths, next-PC select encodings and reset vector for the fetch stage
package if_stage_pkg;
  localparam int IF_TO_ID_BUS_WD = 64;
  localparam int ID_TO_PC_BUS_WD = 98;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;
  typedef struct packed {
    logic [31:0] br_pc;
    logic [31:0] jal_pc;
    logic [31:0] jr_pc;
    npc_sel_e    sel;
  } id_to_pc_t;
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: decode handshake, redirect bus and instruction SRAM port of the fetch stage
interface if_stage_if;
  import if_stage_pkg::*;
  logic [ID_TO_PC_BUS_WD-1:0] ID_to_PC_bus;
  logic                       ID_allow_in;
  logic                       IF_to_ID_valid;
  logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_bus;
  logic                       inst_sram_en;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_rdata;
  modport master (
    input  ID_to_PC_bus, ID_allow_in, inst_sram_rdata,
    output IF_to_ID_valid, IF_to_ID_bus, inst_sram_en, inst_sram_addr
  );
  modport slave (
    output ID_to_PC_bus, ID_allow_in, inst_sram_rdata,
    input  IF_to_ID_valid, IF_to_ID_bus, inst_sram_en, inst_sram_addr
  );
endinterface

// File: rtl/if_inst_buf.sv
// if_inst_buf: holds the fetched instruction across a decode stall so the SRAM may keep reading
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_valid_i,
  input  logic        id_allow_in_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);
  buf_state_e  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  // state and held word register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= BUF_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  // capture on the first stalled cycle, release when decode accepts
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (id_allow_in_i) state_d = BUF_EMPTY;
    else if (fs_valid_i && state_q == BUF_EMPTY) begin
      state_d = BUF_FULL;
      hold_d  = rdata_i;
    end
  end
  assign inst_o = state_q == BUF_FULL ? hold_q : rdata_i;
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch; owns the PC, drives the instruction SRAM, feeds decode (IF_INST_BUF_EN adds a stall holding buffer)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic        clk,
  input logic        resetn,
  if_stage_if.master fs
);
  id_to_pc_t   id_pc;
  logic [31:0] fs_pc_q, fs_pc_d, nextpc, inst;
  logic        fs_valid_q, fs_valid_d, if_allow_in;
  assign id_pc       = fs.ID_to_PC_bus;
  assign if_allow_in = ~fs_valid_q | fs.ID_allow_in;
  // pre-IF next-PC selection; decode's operands only matter on the edge IF advances
  always_comb begin
    nextpc = !resetn              ? RESET_PC :
             id_pc.sel == NPC_BR  ? id_pc.br_pc :
             id_pc.sel == NPC_J   ? id_pc.jal_pc :
             id_pc.sel == NPC_JR  ? id_pc.jr_pc : pc_plus4(fs_pc_q);
    fs_pc_d    = if_allow_in ? nextpc : fs_pc_q;
    fs_valid_d = fs_valid_q | if_allow_in;
  end
  // PC and valid registers; reset PC sits one word before the vector
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_pc_q    <= RESET_PC - 32'd4;
      fs_valid_q <= 1'b0;
    end else begin
      fs_pc_q    <= fs_pc_d;
      fs_valid_q <= fs_valid_d;
    end
  end
`ifdef IF_INST_BUF_EN
  if_inst_buf u_inst_buf (
    .clk          (clk),
    .resetn       (resetn),
    .fs_valid_i   (fs_valid_q),
    .id_allow_in_i(fs.ID_allow_in),
    .rdata_i      (fs.inst_sram_rdata),
    .inst_o       (inst)
  );
  assign fs.inst_sram_en = resetn;
`else
  assign inst            = fs.inst_sram_rdata;
  assign fs.inst_sram_en = resetn & if_allow_in;
`endif
  assign fs.inst_sram_addr = nextpc;
  assign fs.IF_to_ID_valid = fs_valid_q;
  assign fs.IF_to_ID_bus   = {pc_plus4(fs_pc_q), inst};
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against an instruction-stream model
module tb_if_stage;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic clk = 1'b0;
  logic resetn;
  int n_cmp = 0, n_bad = 0;
  logic        r_allow;
  logic [1:0]  r_sel;
  logic [31:0] r_br, r_jal, r_jr;
  bit          m_valid;
  logic [31:0] m_pc;
  if_stage_if fs_if ();
  if_stage #(.RESET_PC(RV)) dut (.clk(clk), .resetn(resetn), .fs(fs_if));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == RV ? 32'h24010001 : (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction
  initial fs_if.inst_sram_rdata = '0;
  always @(posedge clk) if (fs_if.inst_sram_en) fs_if.inst_sram_rdata <= mem_word(fs_if.inst_sram_addr);
  function automatic logic [31:0] exp_next();
    if (!resetn) return RV;
    case (r_sel)
      2'd1: return r_br;
      2'd2: return r_jal;
      2'd3: return r_jr;
      default: return m_pc + 32'd4;
    endcase
  endfunction
  function automatic logic exp_en();
`ifdef IF_INST_BUF_EN
    return resetn;
`else
    return resetn & (!m_valid | r_allow);
`endif
  endfunction
  task automatic drive(input bit rn, input bit allow, input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jal, input logic [31:0] jr);
    resetn = rn; r_allow = allow; r_sel = sel; r_br = br; r_jal = jal; r_jr = jr;
    fs_if.ID_allow_in = allow;
    fs_if.ID_to_PC_bus = {br, jal, jr, sel};
    #1;
  endtask
  task automatic tick();
    logic [31:0] nx;
    @(posedge clk);
    nx = exp_next();
    if (!resetn) begin
      m_valid = 0;
      m_pc = RV - 32'd4;
    end else if (!m_valid || r_allow) begin
      m_valid = 1;
      m_pc = nx;
    end
    @(negedge clk);
  endtask
  task automatic restart();
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); tick();
  endtask
  task automatic test_reset();
    drive(0, 1, 0, 0, 0, 0); tick(); tick();
    n_cmp++; if (fs_if.IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", fs_if.IF_to_ID_valid); end
    n_cmp++; if (fs_if.inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", fs_if.inst_sram_en); end
    n_cmp++; if (fs_if.IF_to_ID_bus[63:32] !== RV) begin n_bad++; $display("FAIL reset_pc4: got %h want %h", fs_if.IF_to_ID_bus[63:32], RV); end
    drive(1, 1, 0, 0, 0, 0);
    n_cmp++; if (fs_if.inst_sram_addr !== 32'hBFC00000) begin n_bad++; $display("FAIL c0_addr: got %h want bfc00000", fs_if.inst_sram_addr); end
    n_cmp++; if (fs_if.inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL c0_en: got %b want 1", fs_if.inst_sram_en); end
    tick();
    n_cmp++; if (fs_if.IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL c1_valid: got %b want 1", fs_if.IF_to_ID_valid); end
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'hBFC00004, 32'h24010001}) begin n_bad++; $display("FAIL c1_bus: got %h want bfc0000424010001", fs_if.IF_to_ID_bus); end
  endtask
  task automatic test_straight();
    for (int i = 1; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 0); tick();
      n_cmp++;
      if (fs_if.IF_to_ID_bus !== {RV + 32'(4 * i + 4), mem_word(RV + 32'(4 * i))} || fs_if.IF_to_ID_valid !== 1'b1) begin
        n_bad++; $display("FAIL straight%0d: got %b/%h want 1/%h", i, fs_if.IF_to_ID_valid, fs_if.IF_to_ID_bus, {RV + 32'(4 * i + 4), mem_word(RV + 32'(4 * i))});
      end
    end
  endtask
  task automatic test_branch();
    restart();
    drive(1, 1, 0, 0, 0, 0); tick();
    n_cmp++; if (fs_if.IF_to_ID_bus[63:32] !== 32'hBFC00008 || fs_if.IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL delay_slot: got %h want bfc00008", fs_if.IF_to_ID_bus[63:32]); end
    drive(1, 1, 2'b01, 32'hBFC00100, 32'h0, 32'h0);
    n_cmp++; if (fs_if.inst_sram_addr !== 32'hBFC00100) begin n_bad++; $display("FAIL br_addr: got %h want bfc00100", fs_if.inst_sram_addr); end
    tick();
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'hBFC00104, mem_word(32'hBFC00100)}) begin n_bad++; $display("FAIL br_target: got %h want %h", fs_if.IF_to_ID_bus, {32'hBFC00104, mem_word(32'hBFC00100)}); end
  endtask
  task automatic test_stall();
    logic [63:0] want;
    restart();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); tick();
    want = {32'hBFC0000C, mem_word(32'hBFC00008)};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++; if (fs_if.inst_sram_en !== exp_en()) begin n_bad++; $display("FAIL stall_en%0d: got %b want %b", i, fs_if.inst_sram_en, exp_en()); end
      tick();
      n_cmp++; if (fs_if.IF_to_ID_bus !== want || fs_if.IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, fs_if.IF_to_ID_bus, want); end
    end
    drive(1, 1, 0, 0, 0, 0);
    n_cmp++; if (fs_if.inst_sram_addr !== 32'hBFC0000C) begin n_bad++; $display("FAIL release_addr: got %h want bfc0000c", fs_if.inst_sram_addr); end
    tick();
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'hBFC00010, mem_word(32'hBFC0000C)}) begin n_bad++; $display("FAIL release_next: got %h want %h", fs_if.IF_to_ID_bus, {32'hBFC00010, mem_word(32'hBFC0000C)}); end
  endtask
  task automatic test_jr_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 2'b11, 0, 0, 32'h80001234); tick();
      n_cmp++; if (fs_if.IF_to_ID_bus[63:32] !== 32'hBFC00010) begin n_bad++; $display("FAIL jr_stall_hold%0d: got %h want bfc00010", i, fs_if.IF_to_ID_bus[63:32]); end
    end
    drive(1, 1, 2'b11, 0, 0, 32'h80001234); tick();
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'h80001238, mem_word(32'h80001234)}) begin n_bad++; $display("FAIL jr_target: got %h want %h", fs_if.IF_to_ID_bus, {32'h80001238, mem_word(32'h80001234)}); end
    drive(1, 1, 0, 0, 0, 0); tick();
    n_cmp++; if (fs_if.IF_to_ID_bus[63:32] !== 32'h8000123C) begin n_bad++; $display("FAIL jr_once: got %h want 8000123c", fs_if.IF_to_ID_bus[63:32]); end
  endtask
  task automatic test_wrap();
    drive(1, 1, 2'b11, 0, 0, 32'hFFFFFFFC); tick();
    n_cmp++; if (fs_if.IF_to_ID_bus[63:32] !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 00000000", fs_if.IF_to_ID_bus[63:32]); end
    drive(1, 1, 0, 0, 0, 0);
    n_cmp++; if (fs_if.inst_sram_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 00000000", fs_if.inst_sram_addr); end
    tick();
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'h4, mem_word(32'h0)}) begin n_bad++; $display("FAIL wrap_next: got %h want %h", fs_if.IF_to_ID_bus, {32'h4, mem_word(32'h0)}); end
  endtask
  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    n_cmp++; if (fs_if.IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", fs_if.IF_to_ID_valid); end
    n_cmp++; if (fs_if.inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_en: got %b want 0", fs_if.inst_sram_en); end
    drive(1, 1, 0, 0, 0, 0);
    n_cmp++; if (fs_if.inst_sram_addr !== RV) begin n_bad++; $display("FAIL mid_rst_addr: got %h want %h", fs_if.inst_sram_addr, RV); end
    tick();
    n_cmp++; if (fs_if.IF_to_ID_bus !== {32'hBFC00004, 32'h24010001} || fs_if.IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rst_restart: got %h want bfc0000424010001", fs_if.IF_to_ID_bus); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3);
      n_cmp++; if (fs_if.inst_sram_addr !== exp_next()) begin n_bad++; $display("FAIL rnd_addr%0d: got %h want %h", i, fs_if.inst_sram_addr, exp_next()); end
      n_cmp++; if (fs_if.inst_sram_en !== exp_en()) begin n_bad++; $display("FAIL rnd_en%0d: got %b want %b", i, fs_if.inst_sram_en, exp_en()); end
      tick();
      n_cmp++; if (fs_if.IF_to_ID_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid%0d: got %b want %b", i, fs_if.IF_to_ID_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (fs_if.IF_to_ID_bus !== {m_pc + 32'd4, mem_word(m_pc)}) begin n_bad++; $display("FAIL rnd_bus%0d: got %h want %h", i, fs_if.IF_to_ID_bus, {m_pc + 32'd4, mem_word(m_pc)}); end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_stall();
    test_jr_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
